// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 32-bit RISC core.
// Owns the program counter and issues fetches to instruction memory over a
// req/ready handshake. Handles stall, halt/resume and redirects (trap, jump,
// taken branch) that arrive while a request is waiting.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   hold PC, issue no new fetch
//   br_taken/br_target      taken branch pulse and target
//   jmp/jmp_target          jump pulse and target
//   trap                    trap pulse, redirects to TRAP_VEC
//   halt/resume             enter / leave HALTED
//   imem_ready              imem accepts the request this cycle
//   imem_req/imem_addr      fetch request and address
//   pc_out/fetch_valid      PC of the delivered fetch, live-fetch pulse
//   misalign                pulse: selected redirect target had addr[1:0] != 0
//
// state  | meaning
// BOOT   | one idle cycle after reset, no request
// RUN    | issue fetches (unless stalled), redirects apply directly
// WAIT   | request presented but not accepted; address frozen
// HALTED | no requests until resume or trap

module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        resume,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        misalign_q, misalign_d;
  // pending redirect: priority 0 = none, 1 = branch, 2 = jump, 3 = trap
  logic [1:0]  pend_prio_q, pend_prio_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        halt_seen_q, halt_seen_d;

  logic [1:0]  redir_prio;
  logic [31:0] redir_tgt;
  logic        redir_mis;
  logic        redirect;
  logic        redir_wins;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign pc_out      = pc_out_q;
  assign fetch_valid = fetch_valid_q;
  assign misalign    = misalign_q;

  // Redirect selection; targets are forced word-aligned, TRAP_VEC never checked.
  always_comb begin
    redir_prio = 2'd0;
    redir_tgt  = pc_q;
    redir_mis  = 1'b0;
    if (trap) begin
      redir_prio = 2'd3;
      redir_tgt  = TRAP_VEC;
    end else if (jmp) begin
      redir_prio = 2'd2;
      redir_tgt  = {jmp_target[31:2], 2'b00};
      redir_mis  = |jmp_target[1:0];
    end else if (br_taken) begin
      redir_prio = 2'd1;
      redir_tgt  = {br_target[31:2], 2'b00};
      redir_mis  = |br_target[1:0];
    end
  end

  assign redirect   = (redir_prio != 2'd0);
  // a new redirect replaces a pending one unless the pending one outranks it
  assign redir_wins = redirect && (redir_prio >= pend_prio_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    fetch_valid_d = 1'b0;
    misalign_d    = 1'b0;
    pend_prio_d   = pend_prio_q;
    pend_addr_d   = pend_addr_q;
    halt_seen_d   = halt_seen_q;
    imem_req      = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        imem_req = !stall;
        if (imem_req && !imem_ready) begin
          // address must stay put from now on; park any redirect
          state_d     = S_WAIT;
          halt_seen_d = halt;
          if (redirect) begin
            pend_prio_d = redir_prio;
            pend_addr_d = redir_tgt;
            misalign_d  = redir_mis;
          end
        end else begin
          if (imem_req && !redirect) begin
            pc_out_d      = pc_q;
            fetch_valid_d = 1'b1;
          end
          if (redirect) begin
            pc_d       = redir_tgt;
            misalign_d = redir_mis;
          end else if (imem_req) begin
            pc_d = pc_plus4;
          end
          if (halt) state_d = S_HALTED;
        end
      end

      S_WAIT: begin
        imem_req    = 1'b1;
        halt_seen_d = halt_seen_q | halt;
        if (redir_wins) begin
          pend_prio_d = redir_prio;
          pend_addr_d = redir_tgt;
          misalign_d  = redir_mis;
        end
        if (imem_ready) begin
          state_d     = (halt_seen_q || halt) ? S_HALTED : S_RUN;
          halt_seen_d = 1'b0;
          pend_prio_d = 2'd0;
          if (redir_wins) begin
            pc_d = redir_tgt;
          end else if (pend_prio_q != 2'd0) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d          = pc_plus4;
            pc_out_d      = pc_q;
            fetch_valid_d = 1'b1;
          end
        end
      end

      S_HALTED: begin
        if (trap) begin
          pc_d    = TRAP_VEC;
          state_d = S_RUN;
        end else if (resume) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VEC;
      pc_out_q      <= 32'd0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      pend_prio_q   <= 2'd0;
      pend_addr_q   <= 32'd0;
      halt_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
      pend_prio_q   <= pend_prio_d;
      pend_addr_q   <= pend_addr_d;
      halt_seen_q   <= halt_seen_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, br_taken, jmp, trap, halt, resume, imem_ready;
  logic [31:0] br_target, jmp_target;
  logic        imem_req, fetch_valid, misalign;
  logic [31:0] imem_addr, pc_out;

  int n_cmp;
  int n_err;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .trap       (trap),
    .halt       (halt),
    .resume     (resume),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_out     (pc_out),
    .fetch_valid(fetch_valid),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    trap = 1'b0; jmp = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; trap = 1'b0;
    halt = 1'b0; resume = 1'b0; imem_ready = 1'b1;
    br_target = 32'd0; jmp_target = 32'd0;

    // reset state
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    // BOOT -> RUN, then sequential fetches 0,4,8,C
    step();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    step();
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_fv0", {31'd0, fetch_valid}, 32'd1);
    chk("seq_pc0", pc_out, 32'h0);
    step();
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_pc4", pc_out, 32'h4);
    step();
    chk("seq_addrC", imem_addr, 32'hC);
    chk("seq_pc8", pc_out, 32'h8);
    step();
    chk("seq_addr10", imem_addr, 32'h10);
    chk("seq_pcC", pc_out, 32'hC);

    // ready low 3 cycles at 0x10, jump to 0x200 during cycle 2
    imem_ready = 1'b0;
    step();
    chk("wait1_addr", imem_addr, 32'h10);
    chk("wait1_req", {31'd0, imem_req}, 32'd1);
    chk("wait1_fv", {31'd0, fetch_valid}, 32'd0);
    jmp = 1'b1; jmp_target = 32'h200;
    step();
    clr_redir();
    chk("wait2_addr", imem_addr, 32'h10);
    step();
    chk("wait3_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    step();
    chk("kill_fv", {31'd0, fetch_valid}, 32'd0);
    chk("jmp_addr", imem_addr, 32'h200);
    step();
    chk("jmp_fv", {31'd0, fetch_valid}, 32'd1);
    chk("jmp_pc", pc_out, 32'h200);
    chk("jmp_next", imem_addr, 32'h204);

    // trap + jmp + br in the same cycle -> TRAP_VEC
    trap = 1'b1; jmp = 1'b1; jmp_target = 32'h80; br_taken = 1'b1; br_target = 32'h40;
    step();
    clr_redir();
    chk("trap_addr", imem_addr, 32'h100);
    chk("trap_fv", {31'd0, fetch_valid}, 32'd0);
    chk("trap_mis", {31'd0, misalign}, 32'd0);
    step();
    chk("trap_pc", pc_out, 32'h100);
    chk("trap_next", imem_addr, 32'h104);

    // misaligned branch target
    br_taken = 1'b1; br_target = 32'h1003;
    step();
    clr_redir();
    chk("br_addr", imem_addr, 32'h1000);
    chk("br_mis", {31'd0, misalign}, 32'd1);

    // stall two cycles: no request, PC held
    stall = 1'b1;
    #1;
    chk("stall_req0", {31'd0, imem_req}, 32'd0);
    step();
    chk("stall1_addr", imem_addr, 32'h1000);
    chk("stall1_mis", {31'd0, misalign}, 32'd0);
    step();
    chk("stall2_addr", imem_addr, 32'h1000);
    chk("stall2_req", {31'd0, imem_req}, 32'd0);
    chk("stall2_fv", {31'd0, fetch_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("unstall_pc", pc_out, 32'h1000);
    chk("unstall_fv", {31'd0, fetch_valid}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h1004);

    // redirect under stall updates PC but issues nothing
    stall = 1'b1; jmp = 1'b1; jmp_target = 32'h300;
    step();
    clr_redir();
    chk("stj_addr", imem_addr, 32'h300);
    chk("stj_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("stj_next", imem_addr, 32'h304);

    // PC+4 wraps at the top of the address space
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    step();
    clr_redir();
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);

    // halt at 0x20, resume at 0x24
    jmp = 1'b1; jmp_target = 32'h20;
    step();
    clr_redir();
    chk("h_addr20", imem_addr, 32'h20);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("h_fv", {31'd0, fetch_valid}, 32'd1);
    chk("h_pc", pc_out, 32'h20);
    chk("h_req", {31'd0, imem_req}, 32'd0);
    chk("h_addr", imem_addr, 32'h24);
    step();
    chk("h2_req", {31'd0, imem_req}, 32'd0);
    chk("h2_fv", {31'd0, fetch_valid}, 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("res_req", {31'd0, imem_req}, 32'd1);
    chk("res_addr", imem_addr, 32'h24);
    step();
    chk("res_next", imem_addr, 32'h28);

    // async reset while waiting
    imem_ready = 1'b0;
    step();
    chk("rw_req", {31'd0, imem_req}, 32'd1);
    chk("rw_pc", pc_out, 32'h24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("arst_mis", {31'd0, misalign}, 32'd0);
    step();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
